// File: rtl/contador_sin_dec_pkg.sv
// Shared defaults for the modulo-N down counter and its flip-flop cell.
// Instances override WIDTH/MODULO; these are the lab's standard 3-bit, mod-8 sizes.
package contador_sin_dec_pkg;

  localparam int unsigned DefWidth  = 3;
  localparam int unsigned DefModulo = 8;

endpackage

// File: rtl/contador_sin_dec_d_ff_sr.sv
// Single-bit D flip-flop with synchronous active-high reset to a per-instance value.
module contador_sin_dec_d_ff_sr #(
  parameter logic RV = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= RV;
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/contador_sin_dec.sv
// Synchronous modulo-N down counter with clamped parallel preset, enable and a
// combinational borrow (tc) for cascading; q and zero are built from DFF cells.
module contador_sin_dec
  import contador_sin_dec_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned MODULO = DefModulo
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o,
  output logic             zero_o
);

  localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             zero_q, zero_d;
  logic             q_is_zero;

  assign q_is_zero = (q_q == '0);

  // Reset is applied inside the cells; this mux covers load > en > hold.
  // Out-of-range states only ever decrement, so they drain back into range.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = (din_i > MaxCount) ? MaxCount : din_i;
    end else if (en_i) begin
      q_d = q_is_zero ? MaxCount : (q_q - WIDTH'(1));
    end
  end

  assign zero_d = (q_d == '0);

  for (genvar i = 0; i < int'(WIDTH); i++) begin : gen_q_bits
    contador_sin_dec_d_ff_sr #(
      .RV (MaxCount[i])
    ) u_q_ff (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (q_d[i]),
      .q_o   (q_q[i])
    );
  end

  contador_sin_dec_d_ff_sr #(
    .RV (1'b0)
  ) u_zero_ff (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (zero_d),
    .q_o   (zero_q)
  );

  assign q_o    = q_q;
  assign zero_o = zero_q;
  assign tc_o   = en_i & ~load_i & ~rst_i & q_is_zero;

endmodule

// File: tb/tb_contador_sin_dec.sv
// Bench for contador_sin_dec: mod-8 and mod-6 instances plus a two-stage cascade,
// checked every cycle against a modular-arithmetic model and a few literal values.
module tb_contador_sin_dec;

  logic       clk;
  logic       rst, en, load;
  logic [2:0] din;
  logic [2:0] q8, q6;
  logic       tc8, tc6, zero8, zero6;

  logic       crst, cen;
  logic [2:0] lq, hq;
  logic       ltc, htc, lzero, hzero;

  int checks   = 0;
  int failures = 0;

  contador_sin_dec #(.WIDTH(3), .MODULO(8)) u_m8 (
    .clk_i (clk), .rst_i (rst), .en_i (en), .load_i (load), .din_i (din),
    .q_o (q8), .tc_o (tc8), .zero_o (zero8)
  );

  contador_sin_dec #(.WIDTH(3), .MODULO(6)) u_m6 (
    .clk_i (clk), .rst_i (rst), .en_i (en), .load_i (load), .din_i (din),
    .q_o (q6), .tc_o (tc6), .zero_o (zero6)
  );

  contador_sin_dec #(.WIDTH(3), .MODULO(8)) u_lo (
    .clk_i (clk), .rst_i (crst), .en_i (cen), .load_i (1'b0), .din_i (3'd0),
    .q_o (lq), .tc_o (ltc), .zero_o (lzero)
  );

  contador_sin_dec #(.WIDTH(3), .MODULO(8)) u_hi (
    .clk_i (clk), .rst_i (crst), .en_i (ltc), .load_i (1'b0), .din_i (3'd0),
    .q_o (hq), .tc_o (htc), .zero_o (hzero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a counter is just an integer stepped modulo its MODULO.
  int mods[2] = '{8, 6};
  int mq[2];
  bit mvalid = 1'b0;
  int cval;
  bit cvalid = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) mq[k] = mods[k] - 1;
      else if (load) mq[k] = (int'(din) > mods[k] - 1) ? mods[k] - 1 : int'(din);
      else if (en) mq[k] = (mq[k] + mods[k] - 1) % mods[k];
    end
    if (rst) mvalid = 1'b1;
    if (crst) begin
      cval   = 63;
      cvalid = 1'b1;
    end else if (cen) begin
      cval = (cval + 63) % 64;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("m8_q", 32'(q8), 32'(mq[0]));
      chk("m8_zero", 32'(zero8), 32'(mq[0] == 0));
      chk("m8_tc", 32'(tc8), 32'(en && !load && !rst && mq[0] == 0));
      chk("m6_q", 32'(q6), 32'(mq[1]));
      chk("m6_zero", 32'(zero6), 32'(mq[1] == 0));
      chk("m6_tc", 32'(tc6), 32'(en && !load && !rst && mq[1] == 0));
    end
    if (cvalid) begin
      chk("casc_q", 32'({hq, lq}), 32'(cval));
      chk("casc_htc", 32'(htc), 32'(cen && !crst && cval == 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    rst = 1'b1; en = 1'b1; load = 1'b0; din = '0;
    crst = 1'b1; cen = 1'b0;

    // Reset held two edges with en high
    tick(); tick();
    chk("rst_q", 32'(q8), 32'd7);
    chk("rst_zero", 32'(zero8), 32'd0);
    chk("rst_tc", 32'(tc8), 32'd0);
    chk("rst_q6", 32'(q6), 32'd5);

    rst = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      tick();
      chk("cnt_q", 32'(q8), 32'(i));
      chk("cnt_zero", 32'(zero8), 32'(i == 0));
    end
    chk("borrow_tc", 32'(tc8), 32'd1);
    tick();
    chk("wrap_q", 32'(q8), 32'd7);
    chk("wrap_tc", 32'(tc8), 32'd0);

    // Free run: 16 cycles from 7 must see exactly two borrows
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      if (tc8) pulses++;
      tick();
    end
    chk("freerun_pulses", 32'(pulses), 32'd2);

    // Preset to zero, then load beats en at q==0
    load = 1'b1; en = 1'b0; din = 3'd0;
    tick();
    chk("load0_q", 32'(q8), 32'd0);
    chk("load0_zero", 32'(zero8), 32'd1);
    en = 1'b1; din = 3'd5;
    #1;
    chk("prio_tc", 32'(tc8), 32'd0);
    tick();
    chk("prio_q", 32'(q8), 32'd5);

    // Clamp on the mod-6 instance
    en = 1'b0; din = 3'd7;
    tick();
    chk("clamp_q6", 32'(q6), 32'd5);
    chk("noclamp_q8", 32'(q8), 32'd7);
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("m6_seq", 32'(q6), 32'((i < 5) ? 4 - i : 5));
    end

    // Hold, then reset beats load
    load = 1'b1; en = 1'b0; din = 3'd3;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_q", 32'(q8), 32'd3);
    end
    rst = 1'b1; load = 1'b1; din = 3'd2; en = 1'b1;
    tick();
    chk("rst_wins_q", 32'(q8), 32'd7);
    rst = 1'b0; load = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      rst  = ($urandom_range(0, 19) == 0);
      load = ($urandom_range(0, 5) == 0);
      en   = ($urandom_range(0, 3) != 0);
      din  = 3'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0; load = 1'b0; en = 1'b0;

    // Cascade: 64 enabled edges go 63..0 and back to 63
    crst = 1'b0; cen = 1'b1;
    pulses = 0;
    for (int i = 0; i < 64; i++) begin
      if (htc) pulses++;
      tick();
    end
    chk("casc_htc_pulses", 32'(pulses), 32'd1);
    chk("casc_final", 32'({hq, lq}), 32'd63);
    cen = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
